// File: rtl/blink_pkg.sv
// Shared types and helpers for the status-LED blink sequencer.
package blink_pkg;

   localparam int unsigned RATE_W    = 4;
   localparam int unsigned PAT_W_DEF = 8;
   localparam int unsigned REP_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Limit the step exponent so the prescaler mask always fits its counter.
   function automatic logic [RATE_W-1:0] clamp_rate(input logic [RATE_W-1:0] rate,
                                                    input int unsigned cnt_w);
      if (32'(rate) > cnt_w - 32'd1) return RATE_W'(cnt_w - 32'd1);
      return rate;
   endfunction

endpackage

// File: rtl/blink_prescaler.sv
// Free-running prescaler; tick fires when the low 'rate' bits are all ones.
module blink_prescaler
   import blink_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              enable,
   input  logic [RATE_W-1:0] rate,
   output logic              tick
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      cnt <= '0;
      else if (clear)  cnt <= '0;
      else if (enable) cnt <= cnt + CNT_W'(1);
   end

   assign mask = CNT_W'((32'd1 << rate) - 32'd1);
   assign tick = enable && ((cnt & mask) == mask);

endmodule

// File: rtl/blink_sequencer.sv
// Programmable LED pattern sequencer. Define BLINK_SEQ_GAP_EN to insert a
// dark gap of PAT_W steps between passes.
module blink_sequencer
   import blink_pkg::*;
#(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned PAT_W = PAT_W_DEF,
   parameter int unsigned REP_W = REP_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [PAT_W-1:0]  cfg_pattern,
   input  logic [RATE_W-1:0] cfg_rate,
   input  logic [REP_W-1:0]  cfg_repeat,
   input  logic              abort,
   output logic              led,
   output logic              busy,
   output logic              done,
   output logic [REP_W-1:0]  pass_count
);

   localparam int unsigned     STEP_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(PAT_W - 1);

   state_t             state;
   logic [PAT_W-1:0]   pat_q;
   logic [PAT_W-1:0]   shreg;
   logic [RATE_W-1:0]  rate_q;
   logic [REP_W-1:0]   rep_q;
   logic [STEP_W-1:0]  step;
   logic [REP_W-1:0]   pass_inc;
   logic               accept;
   logic               tick;

   assign cfg_ready = (state == IDLE);
   assign accept    = cfg_valid && cfg_ready && !abort;
   assign pass_inc  = (pass_count == '1) ? pass_count : pass_count + REP_W'(1);

   blink_prescaler #(.CNT_W(CNT_W)) u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (accept),
      .enable (state != IDLE),
      .rate   (rate_q),
      .tick   (tick)
   );

   // shreg keeps the bit currently on the LED at its MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pat_q      <= '0;
         shreg      <= '0;
         rate_q     <= '0;
         rep_q      <= '0;
         step       <= '0;
         led        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass_count <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  pat_q      <= cfg_pattern;
                  shreg      <= cfg_pattern;
                  rate_q     <= clamp_rate(cfg_rate, CNT_W);
                  rep_q      <= cfg_repeat;
                  step       <= '0;
                  pass_count <= '0;
                  led        <= cfg_pattern[PAT_W-1];
                  busy       <= 1'b1;
                  state      <= RUN;
               end
            end
            RUN: begin
               if (abort) begin
                  state <= IDLE;
                  led   <= 1'b0;
                  busy  <= 1'b0;
               end else if (tick) begin
                  if (step != LAST_STEP) begin
                     step  <= step + STEP_W'(1);
                     led   <= shreg[PAT_W-2];
                     shreg <= {shreg[PAT_W-2:0], 1'b0};
                  end else begin
                     pass_count <= pass_inc;
                     step       <= '0;
                     if (rep_q != '0 && pass_inc == rep_q) begin
                        state <= IDLE;
                        led   <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
`ifdef BLINK_SEQ_GAP_EN
                        led   <= 1'b0;
                        state <= GAP;
`else
                        led   <= pat_q[PAT_W-1];
                        shreg <= pat_q;
`endif
                     end
                  end
               end
            end
`ifdef BLINK_SEQ_GAP_EN
            GAP: begin
               if (abort) begin
                  state <= IDLE;
                  led   <= 1'b0;
                  busy  <= 1'b0;
               end else if (tick) begin
                  if (step != LAST_STEP) begin
                     step <= step + STEP_W'(1);
                  end else begin
                     step  <= '0;
                     led   <= pat_q[PAT_W-1];
                     shreg <= pat_q;
                     state <= RUN;
                  end
               end
            end
`endif
            default: begin
               state <= IDLE;
               led   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
